// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready requesters.
// Round-robin grant, operands/op registered in front of the ALU, result/flag
// registered behind it. One operation is in flight at a time.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  // Request side, port 0
  input  logic             req_valid0,
  output logic             req_ready0,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [OPW-1:0]   req_op0,
  // Request side, port 1
  input  logic             req_valid1,
  output logic             req_ready1,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [OPW-1:0]   req_op1,
  // Response side
  output logic             rsp_valid0,
  input  logic             rsp_ready0,
  output logic             rsp_valid1,
  input  logic             rsp_ready1,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_flag,
  // Shared ALU
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_flag
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q,      state_d;
  logic             owner_q,      owner_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] alu_a_q,      alu_a_d;
  logic [WIDTH-1:0] alu_b_q,      alu_b_d;
  logic [OPW-1:0]   alu_op_q,     alu_op_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_flag_q,   rsp_flag_d;
  logic             grant0,       grant1;
  logic             owner_ack;

  // Round-robin arbitration: a lone requester wins; on a tie the port that
  // was not granted last time wins. Mutually exclusive by construction.
  always_comb begin
    grant0 = req_valid0 & (~req_valid1 | last_grant_q);
    grant1 = req_valid1 & (~req_valid0 | ~last_grant_q);
  end

  // Next-state and request-ready logic; registers hold unless a state acts on them.
  always_comb begin
    // NOTE: every signal written here is given a default first, so no branch
    // leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_result_d = rsp_result_q;
    rsp_flag_d   = rsp_flag_q;
    req_ready0   = 1'b0;
    req_ready1   = 1'b0;
    owner_ack    = owner_q ? rsp_ready1 : rsp_ready0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready0 = grant0;
        req_ready1 = grant1;
        if (grant0) begin
          alu_a_d      = req_a0;
          alu_b_d      = req_b0;
          alu_op_d     = req_op0;
          owner_d      = 1'b0;
          last_grant_d = 1'b0;
          state_d      = ST_EXEC;
        end else if (grant1) begin
          alu_a_d      = req_a1;
          alu_b_d      = req_b1;
          alu_op_d     = req_op1;
          owner_d      = 1'b1;
          last_grant_d = 1'b1;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // ALU has had a full cycle to settle on the registered operands.
        rsp_result_d = alu_result;
        rsp_flag_d   = alu_flag;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        // Only the owning port's ready completes the response.
        if (owner_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; asynchronous reset drops any in-flight op.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_flag_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_flag_q   <= rsp_flag_d;
    end
  end

  assign rsp_valid0 = (state_q == ST_RESP) & ~owner_q;
  assign rsp_valid1 = (state_q == ST_RESP) &  owner_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flag   = rsp_flag_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed vectors, expected responses queued by
// the stimulus thread and consumed by an independent response monitor.
module tb_alu_arbiter;

  localparam int WIDTH = 32;
  localparam int OPW   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid0, req_valid1, req_ready0, req_ready1;
  logic [WIDTH-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [OPW-1:0]   req_op0, req_op1;
  logic             rsp_valid0, rsp_valid1, rsp_ready0, rsp_ready1;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_flag;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [OPW-1:0]   alu_op;
  logic             alu_flag;

  typedef struct {
    bit               port;
    logic [WIDTH-1:0] result;
    logic             flag;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  always #5 clk = ~clk;

  // ALU stub: op 0 -> a+b, op 1 -> a-b, flag = (result == 0)
  always_comb begin
    alu_result = (alu_op == 4'h1) ? (alu_a - alu_b) : (alu_a + alu_b);
    alu_flag   = (alu_result == '0);
  end

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid0 (req_valid0),
    .req_ready0 (req_ready0),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_op0    (req_op0),
    .req_valid1 (req_valid1),
    .req_ready1 (req_ready1),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .req_op1    (req_op1),
    .rsp_valid0 (rsp_valid0),
    .rsp_ready0 (rsp_ready0),
    .rsp_valid1 (rsp_valid1),
    .rsp_ready1 (rsp_ready1),
    .rsp_result (rsp_result),
    .rsp_flag   (rsp_flag),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_flag   (alu_flag)
  );

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic expect_rsp(input bit port, input logic [WIDTH-1:0] res, input logic flg);
    exp_t e;
    e.port = port; e.result = res; e.flag = flg;
    sb.push_back(e);
  endtask

  task automatic drive(input bit port, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [OPW-1:0] op);
    if (port == 1'b0) begin
      req_a0 = a; req_b0 = b; req_op0 = op; req_valid0 = 1'b1;
    end else begin
      req_a1 = a; req_b1 = b; req_op1 = op; req_valid1 = 1'b1;
    end
  endtask

  // Wait (bounded) for port's ready, then drop its valid just after the handshake edge.
  task automatic wait_accept(input bit port);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((port == 1'b0) ? req_ready0 : req_ready1) begin
        got = 1'b1;
        @(posedge clk);
        #1;
        if (port == 1'b0) req_valid0 = 1'b0;
        else              req_valid1 = 1'b0;
      end
    end
    check(port ? "accept_p1" : "accept_p0", {31'd0, got}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    check("drain_empty", sb.size(), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rsp_valid0"}, {31'd0, rsp_valid0}, 32'd0);
    check({tag, "_rsp_valid1"}, {31'd0, rsp_valid1}, 32'd0);
    check({tag, "_rsp_result"}, rsp_result, 32'd0);
    check({tag, "_rsp_flag"},   {31'd0, rsp_flag}, 32'd0);
    check({tag, "_alu_a"},      alu_a, 32'd0);
    check({tag, "_alu_b"},      alu_b, 32'd0);
    check({tag, "_alu_op"},     {28'd0, alu_op}, 32'd0);
  endtask

  // Response monitor: compares each completed response against the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      if (rsp_valid0 && rsp_valid1) check("rsp_valid_onehot", 32'd1, 32'd0);
      if ((rsp_valid0 && rsp_ready0) || (rsp_valid1 && rsp_ready1)) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_port",   {31'd0, rsp_valid1}, {31'd0, e.port});
          check("rsp_result", rsp_result, e.result);
          check("rsp_flag",   {31'd0, rsp_flag}, {31'd0, e.flag});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    req_a0 = '0; req_b0 = '0; req_op0 = '0;
    req_a1 = '0; req_b1 = '0; req_op1 = '0;
    rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;

    // Reset state
    #12;
    check_reset_vals("rst");
    check("rst_req_ready0", {31'd0, req_ready0}, 32'd0);
    check("rst_req_ready1", {31'd0, req_ready1}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // T2: tie right after reset -> p0 first (5+3), then p1 (7-7)
    @(posedge clk); #1;
    drive(1'b0, 32'd5, 32'd3, 4'h0);
    drive(1'b1, 32'd7, 32'd7, 4'h1);
    expect_rsp(1'b0, 32'd8, 1'b0);
    expect_rsp(1'b1, 32'd0, 1'b1);
    #1;
    check("t2_tie_ready0", {31'd0, req_ready0}, 32'd1);
    check("t2_tie_ready1", {31'd0, req_ready1}, 32'd0);
    wait_accept(1'b0);
    wait_accept(1'b1);
    drain();
    // Next tie favours p0 again (last grant was p1)
    @(posedge clk); #1;
    drive(1'b0, 32'd1,  32'd2, 4'h0);
    drive(1'b1, 32'd10, 32'd4, 4'h1);
    expect_rsp(1'b0, 32'd3, 1'b0);
    expect_rsp(1'b1, 32'd6, 1'b0);
    wait_accept(1'b0);
    wait_accept(1'b1);
    drain();

    // T1: single request on p0, latency and quiet p1 outputs
    @(posedge clk); #1;
    drive(1'b0, 32'd5, 32'd3, 4'h0);
    expect_rsp(1'b0, 32'd8, 1'b0);
    @(negedge clk);
    check("t1_ready0", {31'd0, req_ready0}, 32'd1);
    check("t1_ready1", {31'd0, req_ready1}, 32'd0);
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    @(negedge clk);
    check("t1_exec_valid0", {31'd0, rsp_valid0}, 32'd0);
    check("t1_exec_alu_a",  alu_a, 32'd5);
    @(negedge clk);
    check("t1_resp_valid0", {31'd0, rsp_valid0}, 32'd1);
    check("t1_resp_valid1", {31'd0, rsp_valid1}, 32'd0);
    drain();
    repeat (2) @(negedge clk);
    check("t1_idle_alu_a_hold", alu_a, 32'd5);
    check("t1_idle_alu_b_hold", alu_b, 32'd3);

    // T3: backpressure on p0 with p1 pending
    @(posedge clk); #1;
    rsp_ready0 = 1'b0;
    drive(1'b0, 32'd100, 32'd58, 4'h1);
    expect_rsp(1'b0, 32'd42, 1'b0);
    wait_accept(1'b0);
    drive(1'b1, 32'd3, 32'd3, 4'h1);
    expect_rsp(1'b1, 32'd0, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_valid0", {31'd0, rsp_valid0}, 32'd1);
      check("t3_hold_result", rsp_result, 32'd42);
      check("t3_hold_flag",   {31'd0, rsp_flag}, 32'd0);
      check("t3_hold_ready1", {31'd0, req_ready1}, 32'd0);
      check("t3_hold_ready0", {31'd0, req_ready0}, 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready0 = 1'b1;
    wait_accept(1'b1);
    drain();

    // T4: wrap-around add
    @(posedge clk); #1;
    drive(1'b0, 32'hFFFF_FFFF, 32'd1, 4'h0);
    expect_rsp(1'b0, 32'd0, 1'b1);
    wait_accept(1'b0);
    drain();

    // T6: owner p1, stray rsp_ready0 pulse is ignored
    @(posedge clk); #1;
    rsp_ready1 = 1'b0;
    drive(1'b1, 32'd9, 32'd2, 4'h1);
    expect_rsp(1'b1, 32'd7, 1'b0);
    wait_accept(1'b1);
    @(negedge clk);
    @(negedge clk);
    check("t6_valid1", {31'd0, rsp_valid1}, 32'd1);
    @(posedge clk); #1;
    rsp_ready0 = 1'b1;
    @(negedge clk);
    check("t6_pulse_valid0", {31'd0, rsp_valid0}, 32'd0);
    @(posedge clk); #1;
    rsp_ready0 = 1'b0;
    @(negedge clk);
    check("t6_after_valid1", {31'd0, rsp_valid1}, 32'd1);
    check("t6_after_result", rsp_result, 32'd7);
    @(posedge clk); #1;
    rsp_ready1 = 1'b1;
    rsp_ready0 = 1'b1;
    drain();

    // T5a: reset while in EXEC
    @(posedge clk); #1;
    drive(1'b0, 32'd11, 32'd22, 4'h0);
    wait_accept(1'b0);
    #2;
    check("t5a_pre_alu_a", alu_a, 32'd11);
    reset = 1'b1;
    #1;
    check_reset_vals("t5a");
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5a_no_rsp_valid0", {31'd0, rsp_valid0}, 32'd0);
    end

    // T5b: reset while in RESP
    @(posedge clk); #1;
    rsp_ready0 = 1'b0;
    drive(1'b0, 32'd4, 32'd4, 4'h0);
    wait_accept(1'b0);
    @(negedge clk);
    @(negedge clk);
    check("t5b_pre_valid0", {31'd0, rsp_valid0}, 32'd1);
    check("t5b_pre_result", rsp_result, 32'd8);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("t5b");
    @(posedge clk); #1;
    reset = 1'b0;
    rsp_ready0 = 1'b1;

    // After reset the tie goes to p0 again
    @(posedge clk); #1;
    drive(1'b0, 32'd6, 32'd1, 4'h0);
    drive(1'b1, 32'd6, 32'd1, 4'h1);
    expect_rsp(1'b0, 32'd7, 1'b0);
    expect_rsp(1'b1, 32'd5, 1'b0);
    wait_accept(1'b0);
    wait_accept(1'b1);
    drain();

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
